fft_axil_reg_slave: RTL and testbench

FFT_AXIL_REG_SLAVE -- requirements
Module: fft_axil_reg_slave

---
 rtl/fft_axil_reg_slave.sv | 165 ++++++++++++++++
 tb/tb_fft_axil_reg_slave.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_axil_reg_slave.sv
// AXI4-Lite slave with four 32-bit control registers driving the FFT core (reg_out).
// Reads and writes run in independent FSMs; one write outstanding, stall on bready/rready.
module fft_axil_reg_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] reg_out
);

  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int STRB_W = DW / 8;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_VALID} rstate_e;

  wstate_e             wstate_q, wstate_d;
  rstate_e             rstate_q, rstate_d;
  logic                live_q;
  logic [1:0]          widx_q, widx_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic [DW-1:0]       slv_reg_q [4];

  logic                commit;
  logic [1:0]          commit_idx;
  logic [DW-1:0]       commit_data;
  logic [STRB_W-1:0]   commit_strb;
  logic [1:0]          aw_idx;
  logic                unused_bits;

  assign aw_idx      = s00_axi_awaddr[3:2];
  assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  // Write channel: AW and W may arrive in either order or together.
  always_comb begin
    wstate_d        = wstate_q;
    widx_d          = widx_q;
    wdata_d         = wdata_q;
    wstrb_d         = wstrb_q;
    commit          = 1'b0;
    commit_idx      = widx_q;
    commit_data     = wdata_q;
    commit_strb     = wstrb_q;
    s00_axi_awready = 1'b0;
    s00_axi_wready  = 1'b0;
    s00_axi_bvalid  = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        s00_axi_awready = live_q;
        s00_axi_wready  = live_q;
        if (live_q && s00_axi_awvalid && s00_axi_wvalid) begin
          commit      = 1'b1;
          commit_idx  = aw_idx;
          commit_data = s00_axi_wdata;
          commit_strb = s00_axi_wstrb;
          wstate_d    = W_RESP;
        end else if (live_q && s00_axi_awvalid) begin
          widx_d   = aw_idx;
          wstate_d = W_HAVE_AW;
        end else if (live_q && s00_axi_wvalid) begin
          wdata_d  = s00_axi_wdata;
          wstrb_d  = s00_axi_wstrb;
          wstate_d = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        s00_axi_wready = 1'b1;
        if (s00_axi_wvalid) begin
          commit      = 1'b1;
          commit_data = s00_axi_wdata;
          commit_strb = s00_axi_wstrb;
          wstate_d    = W_RESP;
        end
      end
      W_HAVE_W: begin
        s00_axi_awready = 1'b1;
        if (s00_axi_awvalid) begin
          commit     = 1'b1;
          commit_idx = aw_idx;
          wstate_d   = W_RESP;
        end
      end
      default: begin
        s00_axi_bvalid = 1'b1;
        if (s00_axi_bready) wstate_d = W_IDLE;
      end
    endcase
  end

  // Read channel: rdata captured from pre-commit register contents.
  always_comb begin
    rstate_d        = rstate_q;
    rdata_d         = rdata_q;
    s00_axi_arready = 1'b0;
    s00_axi_rvalid  = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        s00_axi_arready = live_q;
        if (live_q && s00_axi_arvalid) begin
          rdata_d  = slv_reg_q[s00_axi_araddr[3:2]];
          rstate_d = R_VALID;
        end
      end
      default: begin
        s00_axi_rvalid = 1'b1;
        if (s00_axi_rready) rstate_d = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      live_q   <= 1'b0;
      wstate_q <= W_IDLE;
      rstate_q <= R_IDLE;
      widx_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      for (int i = 0; i < 4; i++) slv_reg_q[i] <= '0;
    end else begin
      live_q   <= 1'b1;
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
      widx_q   <= widx_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rdata_q  <= rdata_d;
      for (int i = 0; i < 4; i++) begin
        for (int n = 0; n < STRB_W; n++) begin
          if (commit && commit_idx == i[1:0] && commit_strb[n])
            slv_reg_q[i][8*n +: 8] <= commit_data[8*n +: 8];
        end
      end
    end
  end

  assign s00_axi_bresp = 2'b00;
  assign s00_axi_rresp = 2'b00;
  assign s00_axi_rdata = rdata_q;
  assign reg_out       = {slv_reg_q[3], slv_reg_q[2], slv_reg_q[1], slv_reg_q[0]};

endmodule

// File: tb/tb_fft_axil_reg_slave.sv
// Bench for fft_axil_reg_slave: shadow register model plus a queue of expected read data.
module tb_fft_axil_reg_slave;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   awaddr = '0;
  logic [2:0]   awprot = '0;
  logic         awvalid = 1'b0;
  logic         awready;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         wvalid = 1'b0;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready = 1'b0;
  logic [3:0]   araddr = '0;
  logic [2:0]   arprot = '0;
  logic         arvalid = 1'b0;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready = 1'b0;
  logic [127:0] reg_out;

  int total = 0;
  int bad = 0;
  logic [31:0] model [4];
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  fft_axil_reg_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .reg_out(reg_out)
  );

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v, input logic [3:0] s);
    logic [31:0] r;
    r = old_v;
    for (int n = 0; n < 4; n++) if (s[n]) r[8*n +: 8] = new_v[8*n +: 8];
    return r;
  endfunction

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output bit ok);
    bit awd, wd, ah, wh;
    int cyc;
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    awd = 0; wd = 0; cyc = 0; resp = 2'bxx;
    while (!(awd && wd) && cyc < 20) begin
      @(negedge clk); ah = awvalid && awready; wh = wvalid && wready;
      @(posedge clk); #1;
      if (ah) begin awvalid = 1'b0; awd = 1; end
      if (wh) begin wvalid = 1'b0; wd = 1; end
      cyc++;
    end
    ok = 0;
    if (awd && wd) begin
      cyc = 0;
      while (!ok && cyc < 20) begin
        @(negedge clk);
        if (bvalid) begin ok = 1; resp = bresp; end
        @(posedge clk); #1;
        cyc++;
      end
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    if (!ok) begin total++; bad++; $display("FAIL write_timeout addr=%h", a); end
    else model[a[3:2]] = merge(model[a[3:2]], d, s);
  endtask

  task automatic do_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp, output bit ok);
    bit acc;
    int cyc;
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    exp_q.push_back(model[a[3:2]]);
    acc = 0; ok = 0; cyc = 0; d = 'x; resp = 2'bxx;
    while (!acc && cyc < 20) begin
      @(negedge clk); acc = arready;
      @(posedge clk); #1; cyc++;
    end
    arvalid = 1'b0;
    cyc = 0;
    while (acc && !ok && cyc < 20) begin
      @(negedge clk);
      if (rvalid) begin ok = 1; d = rdata; resp = rresp; end
      @(posedge clk); #1; cyc++;
    end
    rready = 1'b0;
    if (!ok) begin total++; bad++; $display("FAIL read_timeout addr=%h", a); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
      bad++; $display("FAIL reset_hs got=%b want=00000", {awready, wready, arready, bvalid, rvalid});
    end
    total++;
    if ({rdata, bresp, rresp} !== 36'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", rdata); end
    total++;
    if (reg_out !== 128'h0) begin bad++; $display("FAIL reset_regout got=%h want=0", reg_out); end
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({awready, wready, arready} !== 3'b000) begin
      bad++; $display("FAIL ready_before_edge got=%b want=000", {awready, wready, arready});
    end
    @(negedge clk);
    total++;
    if ({awready, wready, arready} !== 3'b111) begin
      bad++; $display("FAIL ready_after_edge got=%b want=111", {awready, wready, arready});
    end
  endtask

  task automatic test_seq_write_read();
    logic [1:0] r; logic [31:0] d, e; bit ok;
    for (int i = 0; i < 4; i++) begin
      do_write(4'(i * 4), 32'(i + 1), 4'hF, r, ok);
      total++;
      if (ok && r !== 2'b00) begin bad++; $display("FAIL seq_bresp got=%b want=00", r); end
    end
    for (int i = 0; i < 4; i++) begin
      do_read(4'(i * 4), d, r, ok);
      e = exp_q.pop_front();
      total++;
      if (ok && (d !== e || d !== 32'(i + 1) || r !== 2'b00)) begin
        bad++; $display("FAIL seq_read idx=%0d got=%h/%b want=%h/00", i, d, r, e);
      end
    end
    total++;
    if (reg_out !== 128'h00000004_00000003_00000002_00000001) begin
      bad++; $display("FAIL seq_regout got=%h want=00000004000000030000000200000001", reg_out);
    end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] r; logic [31:0] d, e; bit ok; int pulses;
    bready = 1'b1;
    @(posedge clk); #1; wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    total++;
    if (wready !== 1'b1) begin bad++; $display("FAIL wfirst_accept got=%b want=1", wready); end
    @(posedge clk); #1; wvalid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if (wready !== 1'b0 || awready !== 1'b1 || bvalid !== 1'b0) begin
        bad++; $display("FAIL wfirst_hold w=%b aw=%b b=%b want=0/1/0", wready, awready, bvalid);
      end
      @(posedge clk); #1;
    end
    awaddr = 4'h8; awvalid = 1'b1;
    @(negedge clk);
    total++;
    if (awready !== 1'b1) begin bad++; $display("FAIL wfirst_aw got=%b want=1", awready); end
    @(posedge clk); #1; awvalid = 1'b0;
    model[2] = 32'hDEADBEEF;
    pulses = 0;
    repeat (6) begin @(negedge clk); if (bvalid) pulses++; end
    @(posedge clk); #1; bready = 1'b0;
    total++;
    if (pulses !== 1) begin bad++; $display("FAIL wfirst_bpulses got=%0d want=1", pulses); end
    do_read(4'h8, d, r, ok);
    e = exp_q.pop_front();
    total++;
    if (ok && (d !== e || d !== 32'hDEADBEEF)) begin bad++; $display("FAIL wfirst_read got=%h want=deadbeef", d); end
  endtask

  task automatic test_strobe();
    logic [1:0] r; logic [31:0] d, e; bit ok;
    do_write(4'h4, 32'h11223344, 4'hF, r, ok);
    do_write(4'h4, 32'hAABBCCDD, 4'h5, r, ok);
    do_read(4'h4, d, r, ok);
    e = exp_q.pop_front();
    total++;
    if (ok && (d !== e || d !== 32'h11BB33DD)) begin bad++; $display("FAIL strobe_read got=%h want=11bb33dd", d); end
  endtask

  task automatic test_rready_stall();
    logic [31:0] e;
    @(posedge clk); #1; araddr = 4'hC; arvalid = 1'b1; rready = 1'b0;
    exp_q.push_back(model[3]);
    @(negedge clk);
    total++;
    if (arready !== 1'b1) begin bad++; $display("FAIL rstall_ar got=%b want=1", arready); end
    @(posedge clk); #1; arvalid = 1'b0;
    e = exp_q.pop_front();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (rvalid !== 1'b1 || rdata !== e || rdata !== 32'h4 || arready !== 1'b0) begin
        bad++; $display("FAIL rstall_hold c=%0d rv=%b d=%h ar=%b want=1/%h/0", c, rvalid, rdata, arready, e);
      end
      @(posedge clk); #1;
    end
    rready = 1'b1;
    @(posedge clk); #1; rready = 1'b0;
    @(negedge clk);
    total++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      bad++; $display("FAIL rstall_release rv=%b ar=%b want=0/1", rvalid, arready);
    end
  endtask

  task automatic test_bready_stall();
    logic [1:0] r; logic [31:0] d, e; bit ok;
    @(posedge clk); #1;
    awaddr = 4'hC; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    model[3] = 32'h77;
    awaddr = 4'h0; wdata = 32'h55;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) begin
        bad++; $display("FAIL bstall_hold c=%0d b=%b aw=%b w=%b want=1/0/0", c, bvalid, awready, wready);
      end
      @(posedge clk); #1;
    end
    bready = 1'b1;
    @(negedge clk);
    total++;
    if (bvalid !== 1'b1 || awready !== 1'b0) begin bad++; $display("FAIL bstall_rel b=%b aw=%b want=1/0", bvalid, awready); end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (awready !== 1'b1 || bvalid !== 1'b0) begin bad++; $display("FAIL bstall_next aw=%b b=%b want=1/0", awready, bvalid); end
    @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0;
    model[0] = 32'h55;
    @(negedge clk);
    total++;
    if (bvalid !== 1'b1) begin bad++; $display("FAIL bstall_second_b got=%b want=1", bvalid); end
    @(posedge clk); #1; bready = 1'b0;
    total++;
    if (reg_out[127:96] !== model[3]) begin bad++; $display("FAIL bstall_reg3 got=%h want=%h", reg_out[127:96], model[3]); end
    do_read(4'h0, d, r, ok);
    e = exp_q.pop_front();
    total++;
    if (ok && d !== e) begin bad++; $display("FAIL bstall_read0 got=%h want=%h", d, e); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    @(posedge clk); #1;
    awaddr = 4'h0; wdata = 32'hA5A5A5A5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 4'h0; arvalid = 1'b1; rready = 1'b0; bready = 1'b0;
    exp_q.push_back(model[0]);
    model[0] = 32'hA5A5A5A5;
    @(negedge clk);
    total++;
    if ({awready, wready, arready} !== 3'b111) begin
      bad++; $display("FAIL b2b_accept got=%b want=111", {awready, wready, arready});
    end
    @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    total++;
    if (rvalid !== 1'b1 || bvalid !== 1'b1 || rdata !== e) begin
      bad++; $display("FAIL b2b_prewrite rv=%b bv=%b d=%h want=1/1/%h", rvalid, bvalid, rdata, e);
    end
    @(posedge clk); #1; rready = 1'b1; bready = 1'b1;
    @(posedge clk); #1; rready = 1'b0; bready = 1'b0;
    awaddr = 4'h4; wdata = 32'h0F0F0F0F; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    model[1] = 32'h0F0F0F0F;
    araddr = 4'h4; arvalid = 1'b1; rready = 1'b1;
    exp_q.push_back(model[1]);
    @(negedge clk);
    total++;
    if (arready !== 1'b1) begin bad++; $display("FAIL b2b_ar_next got=%b want=1", arready); end
    @(posedge clk); #1; arvalid = 1'b0; bready = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    total++;
    if (rvalid !== 1'b1 || rdata !== e) begin bad++; $display("FAIL b2b_rdw rv=%b d=%h want=1/%h", rvalid, rdata, e); end
    @(posedge clk); #1; rready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [1:0] r; logic [31:0] d, e; bit ok;
    @(posedge clk); #1; awaddr = 4'h0; awvalid = 1'b1; wvalid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1; awvalid = 1'b0; wdata = 32'h0BAD0BAD; wstrb = 4'hF;
    @(negedge clk);
    total++;
    if (wready !== 1'b1 || awready !== 1'b0) begin bad++; $display("FAIL rmid_have_aw w=%b aw=%b want=1/0", wready, awready); end
    rst_n = 1'b0;
    #2;
    total++;
    if ({bvalid, rvalid, awready, wready, arready} !== 5'b0 || reg_out !== 128'h0) begin
      bad++; $display("FAIL rmid_in_reset flags=%b regout=%h want=0/0", {bvalid, rvalid, awready, wready, arready}, reg_out);
    end
    for (int i = 0; i < 4; i++) model[i] = '0;
    @(posedge clk); #1; rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (bvalid !== 1'b0 || reg_out !== 128'h0) begin
        bad++; $display("FAIL rmid_after b=%b regout=%h want=0/0", bvalid, reg_out);
      end
    end
    do_read(4'h0, d, r, ok);
    e = exp_q.pop_front();
    total++;
    if (ok && (d !== e || d !== 32'h0)) begin bad++; $display("FAIL rmid_read0 got=%h want=0", d); end
    do_read(4'h8, d, r, ok);
    e = exp_q.pop_front();
    total++;
    if (ok && (d !== e || r !== 2'b00)) begin bad++; $display("FAIL rmid_read8 got=%h/%b want=%h/00", d, r, e); end
  endtask

  initial begin
    test_reset();
    test_seq_write_read();
    test_w_before_aw();
    test_strobe();
    test_rready_stall();
    test_bready_stall();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
